// File: rtl/divider_nbit_sm.sv
// Restoring unsigned divider with Start/Ack handshake and one-hot state outputs.
// Produces one quotient bit per clock; a zero divisor short-circuits straight to DONE.
module divider_nbit_sm #(
    parameter int WIDTH = 8
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    input  logic             Start,
    input  logic             Ack,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Done,
    output logic             Qi,
    output logic             Qc,
    output logic             Qd
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_INIT = 3'b001,
        S_COMP = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic             qb;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] x_next;

    // R never exceeds Y-1, so its low WIDTH bits carry the full partial remainder.
    always_comb begin
        trial  = {r_q[WIDTH-1:0], x_q[WIDTH-1]};
        qb     = (trial >= {1'b0, y_q});
        r_next = qb ? (trial - {1'b0, y_q}) : trial;
        x_next = {x_q[WIDTH-2:0], qb};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_INIT: begin
                if (Start) begin
                    if (Yin != '0) begin
                        x_d     = Xin;
                        y_d     = Yin;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        dbz_d   = 1'b0;
                        state_d = S_COMP;
                    end else begin
                        quo_d   = '1;
                        rem_d   = Xin;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_COMP: begin
                x_d   = x_next;
                r_d   = r_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = x_next;
                    rem_d   = r_next[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;
    assign Qi        = (state_q == S_INIT);
    assign Qc        = (state_q == S_COMP);
    assign Qd        = (state_q == S_DONE);
    assign Done      = Qd;

endmodule

// File: tb/tb_divider_nbit_sm.sv
// Bench for divider_nbit_sm: directed and random divisions on 8- and 16-bit instances,
// checked against plain integer division.
module tb_divider_nbit_sm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  x8, y8, q8, r8;
    logic        s8, a8, dbz8, d8, qi8, qc8, qd8;
    logic [15:0] x16, y16, q16, r16;
    logic        s16, a16, dbz16, d16, qi16, qc16, qd16;

    int tests  = 0;
    int failed = 0;

    divider_nbit_sm #(.WIDTH(8)) dut8 (
        .ClkPort(clk), .Reset(rst), .Xin(x8), .Yin(y8), .Start(s8), .Ack(a8),
        .Quotient(q8), .Remainder(r8), .DivByZero(dbz8), .Done(d8),
        .Qi(qi8), .Qc(qc8), .Qd(qd8)
    );

    divider_nbit_sm #(.WIDTH(16)) dut16 (
        .ClkPort(clk), .Reset(rst), .Xin(x16), .Yin(y16), .Start(s16), .Ack(a16),
        .Quotient(q16), .Remainder(r16), .DivByZero(dbz16), .Done(d16),
        .Qi(qi16), .Qc(qc16), .Qd(qd16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] st(input int w);
        return (w == 8) ? {qi8, qc8, qd8} : {qi16, qc16, qd16};
    endfunction

    function automatic logic [31:0] quo(input int w);
        return (w == 8) ? {24'd0, q8} : {16'd0, q16};
    endfunction

    function automatic logic [31:0] rem(input int w);
        return (w == 8) ? {24'd0, r8} : {16'd0, r16};
    endfunction

    // Reference: ordinary integer division, all-ones quotient for a zero divisor.
    task automatic ref_div(input int w, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        if (y == 0) begin
            q = (32'd1 << w) - 1;
            r = x;
            z = 1'b1;
        end else begin
            q = x / y;
            r = x % y;
            z = 1'b0;
        end
    endtask

    task automatic start(input int w, input logic [31:0] x, input logic [31:0] y);
        if (w == 8) begin
            x8 = x[7:0]; y8 = y[7:0]; s8 = 1'b1;
        end else begin
            x16 = x[15:0]; y16 = y[15:0]; s16 = 1'b1;
        end
        step();
        s8 = 1'b0;
        s16 = 1'b0;
    endtask

    task automatic wait_done(input int w, input int lat, input string tag);
        int n = 0;
        while (((w == 8) ? d8 : d16) !== 1'b1 && n < 40) begin
            step();
            n++;
            if (w == 16 && n == 3) begin
                x16 = ~x16;
                y16 = ~y16;
            end
        end
        check({tag, " latency"}, n, lat);
    endtask

    task automatic check_result(input int w, input logic [31:0] x, input logic [31:0] y,
                                input string tag);
        logic [31:0] eq, er;
        logic        ez;
        ref_div(w, x, y, eq, er, ez);
        check({tag, " quotient"}, quo(w), eq);
        check({tag, " remainder"}, rem(w), er);
        check({tag, " dbz"}, (w == 8) ? dbz8 : dbz16, ez);
        check({tag, " state done"}, st(w), 3'b001);
        check({tag, " done"}, (w == 8) ? d8 : d16, 1'b1);
    endtask

    task automatic ack(input int w, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] eq, er;
        logic        ez;
        ref_div(w, x, y, eq, er, ez);
        if (w == 8) a8 = 1'b1; else a16 = 1'b1;
        step();
        a8 = 1'b0;
        a16 = 1'b0;
        check({tag, " ack->init"}, st(w), 3'b100);
        step();
        check({tag, " held quotient"}, quo(w), eq);
        check({tag, " held remainder"}, rem(w), er);
    endtask

    task automatic run(input int w, input logic [31:0] x, input logic [31:0] y, input string tag);
        start(w, x, y);
        check({tag, " state after start"}, st(w), (y != 0) ? 3'b010 : 3'b001);
        wait_done(w, (y != 0) ? w : 0, tag);
        check_result(w, x, y, tag);
        ack(w, x, y, tag);
    endtask

    initial begin
        rst = 1'b1;
        x8 = '0; y8 = '0; s8 = 1'b0; a8 = 1'b0;
        x16 = '0; y16 = '0; s16 = 1'b0; a16 = 1'b0;
        step();
        step();
        check("reset state", st(8), 3'b100);
        check("reset quotient", quo(8), 0);
        check("reset remainder", rem(8), 0);
        check("reset dbz", dbz8, 1'b0);
        check("reset done", d8, 1'b0);
        rst = 1'b0;
        step();
        check("idle without start", st(8), 3'b100);

        run(8, 200, 7, "d200_7");
        run(8, 5, 9, "d5_9");
        run(8, 255, 255, "d255_255");
        run(8, 255, 1, "d255_1");
        run(8, 8'h3C, 0, "dbz3c");
        run(16, 65535, 255, "w16_65535_255");

        // Asynchronous reset three edges into COMPUTE
        start(8, 200, 7);
        step();
        step();
        step();
        check("pre-reset compute", st(8), 3'b010);
        #2 rst = 1'b1;
        #1;
        check("async reset state", st(8), 3'b100);
        check("async reset quotient", quo(8), 0);
        check("async reset remainder", rem(8), 0);
        rst = 1'b0;
        run(8, 100, 10, "after_reset");

        // Ack ignored in COMPUTE; Start+Ack in DONE returns to INITIAL then restarts
        start(8, 50, 6);
        a8 = 1'b1;
        step();
        a8 = 1'b0;
        check("ack in compute ignored", st(8), 3'b010);
        wait_done(8, 7, "d50_6");
        check_result(8, 50, 6, "d50_6");
        x8 = 77;
        y8 = 5;
        s8 = 1'b1;
        a8 = 1'b1;
        step();
        check("start+ack -> init", st(8), 3'b100);
        step();
        s8 = 1'b0;
        a8 = 1'b0;
        check("held start restarts", st(8), 3'b010);
        wait_done(8, 8, "d77_5");
        check_result(8, 77, 5, "d77_5");
        ack(8, 77, 5, "d77_5");

        for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            x = $urandom_range(0, 255);
            y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            run(8, x, y, $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom_range(0, 65535);
            y = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 65535);
            run(16, x, y, $sformatf("rnd16_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
